// File: rtl/dmem_mmio.sv
// dmem_mmio: zero-wait-state data-memory responder for the core's DMEM bus.
// Word RAM at [0, 4*data_size) plus an MMIO window at MMIO_BASE holding the LED
// register, the synchronised switch input, a prescaled timer with compare/match,
// and a STATUS register with W1C match and sticky bus-error flags.
// Optional feature macro: DMEM_TIMER_EN (defined -> timer present; undefined ->
// timer removed, TCOUNT/TCMP read 0 and ignore writes, tmr_match tied low).

module dmem_mmio #(
  parameter int unsigned               data_size    = 1024,
  parameter int unsigned               address_size = 32,
  parameter logic [address_size-1:0]   MMIO_BASE    = 32'h0001_0000,
  parameter int unsigned               PRESCALE     = 50,
  parameter int unsigned               LED_W        = 10,
  parameter int unsigned               SW_W         = 10
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [address_size-1:0] daddr,
  input  logic [address_size-1:0] ddata_w,
  input  logic                    MemRead,
  input  logic                    MemWrite,
  output logic [address_size-1:0] ddata_r,
  input  logic [SW_W-1:0]         sw_in,
  output logic [LED_W-1:0]        led_out,
  output logic                    tmr_match,
  output logic                    bus_err
);

  localparam int unsigned AW = $clog2(data_size);
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // Address decode. Byte offset bits are ignored everywhere.
  logic          w_ram_sel, w_win, w_mapped, w_err_set, w_ram_we;
  logic          w_sel_led, w_sel_sw, w_sel_tcnt, w_sel_tcmp, w_sel_stat;
  logic [13:0]   w_reg_idx;
  logic [AW-1:0] w_widx;
  logic          w_unused;

  assign w_ram_sel  = (daddr[address_size-1:AW+2] == '0);
  assign w_win      = ~w_ram_sel && (daddr[address_size-1:16] == MMIO_BASE[address_size-1:16]);
  assign w_reg_idx  = daddr[15:2];
  assign w_sel_led  = w_win && (w_reg_idx == 14'd0);
  assign w_sel_sw   = w_win && (w_reg_idx == 14'd1);
  assign w_sel_tcnt = w_win && (w_reg_idx == 14'd2);
  assign w_sel_tcmp = w_win && (w_reg_idx == 14'd3);
  assign w_sel_stat = w_win && (w_reg_idx == 14'd4);
  assign w_mapped   = w_ram_sel | w_sel_led | w_sel_sw | w_sel_tcnt | w_sel_tcmp | w_sel_stat;
  assign w_err_set  = (MemRead | MemWrite) & ~w_mapped;
  assign w_widx     = daddr[AW+1:2];
  // RAM is not reset, so a write landing while reset is held must be masked here.
  assign w_ram_we   = MemWrite & w_ram_sel & RESET_N;
  assign w_unused   = ^daddr[1:0];

  // Storage
  logic [address_size-1:0] r_ram [data_size];
  logic [LED_W-1:0]        r_led;
  logic [SW_W-1:0]         r_sw_s1, r_sw_s2;
  logic                    r_bus_err;
  logic                    w_match;
  logic [address_size-1:0] w_tcount, w_tcmp;

  // RAM write port, no reset on contents.
  always_ff @(posedge CLK) begin
    if (w_ram_we) r_ram[w_widx] <= ddata_w;
  end

  // LED register, switch synchroniser and sticky bus-error flag; new error beats W1C.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_led     <= '0;
      r_sw_s1   <= '0;
      r_sw_s2   <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_sw_s1 <= sw_in;
      r_sw_s2 <= r_sw_s1;
      if (MemWrite && w_sel_led) r_led <= ddata_w[LED_W-1:0];
      if (w_err_set) begin
        r_bus_err <= 1'b1;
      end else if (MemWrite && w_sel_stat && ddata_w[1]) begin
        r_bus_err <= 1'b0;
      end
    end
  end

`ifdef DMEM_TIMER_EN
  logic [PW-1:0]           r_pre;
  logic [address_size-1:0] r_tcount, r_tcmp;
  logic                    r_match;
  logic                    w_tick, w_wr_tcnt, w_match_set;

  assign w_tick      = (r_pre == PW'(PRESCALE - 1));
  assign w_wr_tcnt   = MemWrite & w_sel_tcnt;
  // Match only when the tick really advances TCOUNT (a bus write overrides it).
  assign w_match_set = w_tick & ~w_wr_tcnt & ((r_tcount + 1'b1) == r_tcmp);

  // Prescaler, TCOUNT/TCMP and match flag; match set beats W1C.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pre    <= '0;
      r_tcount <= '0;
      r_tcmp   <= '1;
      r_match  <= 1'b0;
    end else begin
      if (w_wr_tcnt) begin
        r_tcount <= ddata_w;
        r_pre    <= '0;
      end else begin
        r_pre <= w_tick ? '0 : r_pre + 1'b1;
        if (w_tick) r_tcount <= r_tcount + 1'b1;
      end
      if (MemWrite && w_sel_tcmp) r_tcmp <= ddata_w;
      if (w_match_set) begin
        r_match <= 1'b1;
      end else if (MemWrite && w_sel_stat && ddata_w[0]) begin
        r_match <= 1'b0;
      end
    end
  end

  assign w_tcount = r_tcount;
  assign w_tcmp   = r_tcmp;
  assign w_match  = r_match;
`else
  assign w_tcount = '0;
  assign w_tcmp   = '0;
  assign w_match  = 1'b0;
`endif

  // Combinational read mux; zero when not reading or unmapped.
  always_comb begin
    ddata_r = '0;
    if (MemRead) begin
      if (w_ram_sel) begin
        ddata_r = r_ram[w_widx];
      end else if (w_sel_led) begin
        ddata_r[LED_W-1:0] = r_led;
      end else if (w_sel_sw) begin
        ddata_r[SW_W-1:0] = r_sw_s2;
      end else if (w_sel_tcnt) begin
        ddata_r = w_tcount;
      end else if (w_sel_tcmp) begin
        ddata_r = w_tcmp;
      end else if (w_sel_stat) begin
        ddata_r[1:0] = {r_bus_err, w_match};
      end
    end
  end

  assign led_out   = r_led;
  assign tmr_match = w_match;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed steps plus a randomized phase, checked against a
// cycle-level behavioural model of the memory map kept in the bench.
module tb_dmem_mmio;
  localparam int unsigned DS  = 256;
  localparam int unsigned PS  = 3;
  localparam logic [31:0] MB  = 32'h0001_0000;
  localparam logic [31:0] RAM_END = 32'(4 * DS);
`ifdef DMEM_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic        CLK = 1'b0, RESET_N = 1'b0;
  logic [31:0] daddr = '0, ddata_w = '0, ddata_r;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [9:0]  sw_in = '0, led_out;
  logic        tmr_match, bus_err;

  int checks = 0, errors = 0;

  dmem_mmio #(
    .data_size(DS), .address_size(32), .MMIO_BASE(MB),
    .PRESCALE(PS), .LED_W(10), .SW_W(10)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .daddr(daddr), .ddata_w(ddata_w),
    .MemRead(MemRead), .MemWrite(MemWrite), .ddata_r(ddata_r), .sw_in(sw_in),
    .led_out(led_out), .tmr_match(tmr_match), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  logic [31:0] m_ram [int];
  logic [9:0]  m_led, m_s1, m_s2;
  int unsigned m_pre;
  logic [31:0] m_tcnt, m_tcmp;
  logic        m_match, m_err;

  task automatic m_reset();
    m_led = '0; m_s1 = '0; m_s2 = '0; m_pre = 0;
    m_tcnt = '0; m_tcmp = 32'hFFFF_FFFF; m_match = 1'b0; m_err = 1'b0;
  endtask

  function automatic bit m_mapped(input logic [31:0] a);
    return (a < RAM_END) || (a == MB) || (a == MB + 4) || (a == MB + 8) ||
           (a == MB + 32'hC) || (a == MB + 32'h10);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic rd);
    if (!rd) return 32'd0;
    if (a < RAM_END) return m_ram.exists(int'(a >> 2)) ? m_ram[int'(a >> 2)] : 32'hxxxx_xxxx;
    if (a == MB) return {22'd0, m_led};
    if (a == MB + 4) return {22'd0, m_s2};
    if (a == MB + 8) return TMR ? m_tcnt : 32'd0;
    if (a == MB + 32'hC) return TMR ? m_tcmp : 32'd0;
    if (a == MB + 32'h10) return {30'd0, m_err, TMR ? m_match : 1'b0};
    return 32'd0;
  endfunction

  // One clock edge of the memory map's rules, from the pre-edge state.
  task automatic m_step(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                        input logic wr, input logic [9:0] sw);
    bit          unm, tick, wtc, clr_m, clr_e, set_m;
    logic [31:0] adv;
    unm   = (rd || wr) && !m_mapped(a);
    clr_m = wr && (a == MB + 32'h10) && wd[0];
    clr_e = wr && (a == MB + 32'h10) && wd[1];
    if (TMR) begin
      tick  = (m_pre == PS - 1);
      wtc   = wr && (a == MB + 8);
      adv   = m_tcnt + 32'd1;
      set_m = tick && !wtc && (adv == m_tcmp);
      if (wtc) begin
        m_tcnt = wd;
        m_pre  = 0;
      end else begin
        m_pre = (m_pre + 1) % PS;
        if (tick) m_tcnt = adv;
      end
      if (wr && a == MB + 32'hC) m_tcmp = wd;
      m_match = set_m || (m_match && !clr_m);
    end
    m_err = unm || (m_err && !clr_e);
    if (wr && a < RAM_END) m_ram[int'(a >> 2)] = wd;
    if (wr && a == MB) m_led = wd[9:0];
    m_s2 = m_s1;
    m_s1 = sw;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: check combinational read data, clock, then check registered outputs.
  task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input logic rd, input logic wr);
    daddr = a; ddata_w = wd; MemRead = rd; MemWrite = wr;
    #1;
    chk("rdata", ddata_r, m_read(a, rd));
    @(posedge CLK);
    m_step(a, wd, rd, wr, sw_in);
    #1;
    chk("led_out", 32'(led_out), 32'(m_led));
    chk("tmr_match", 32'(tmr_match), 32'(m_match));
    chk("bus_err", 32'(bus_err), 32'(m_err));
  endtask

  // Combinational read peek against a fixed expectation; no clock edge.
  task automatic look(input string tag, input logic [31:0] a, input logic rd,
                      input logic [31:0] exp);
    daddr = a; MemRead = rd; MemWrite = 1'b0;
    #1;
    chk(tag, ddata_r, exp);
  endtask

  initial begin
    int          n;
    int unsigned sel;
    logic [31:0] a, wd;
    logic        rd, wr;

    m_reset();
    #12;
    chk("rst_led", 32'(led_out), 32'd0);
    chk("rst_flags", {30'd0, tmr_match, bus_err}, 32'd0);
    RESET_N = 1'b1;
    cyc(32'h0, 32'h0, 1'b0, 1'b0);
    look("rst_tcmp", MB + 32'hC, 1'b1, TMR ? 32'hFFFF_FFFF : 32'd0);
    look("rst_status", MB + 32'h10, 1'b1, 32'd0);

    // RAM basics and boundary
    cyc(32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1);
    look("ram_rd", 32'h10, 1'b1, 32'hDEAD_BEEF);
    look("ram_rd_unaligned", 32'h13, 1'b1, 32'hDEAD_BEEF);
    look("ram_no_rd", 32'h10, 1'b0, 32'd0);
    cyc(RAM_END - 4, 32'h1234_5678, 1'b0, 1'b1);
    look("ram_top", RAM_END - 4, 1'b1, 32'h1234_5678);
    look("ram_end_unmapped", RAM_END, 1'b1, 32'd0);
    cyc(RAM_END, 32'h0, 1'b1, 1'b0);
    chk("ram_end_err", 32'(bus_err), 32'd1);
    cyc(MB + 32'h10, 32'h2, 1'b0, 1'b1);
    chk("err_clear0", 32'(bus_err), 32'd0);

    // LED and switch synchroniser
    cyc(MB, 32'hFFFF_F3A5, 1'b0, 1'b1);
    chk("led_val", 32'(led_out), 32'h3A5);
    sw_in = 10'h155;
    cyc(MB + 4, 32'h0, 1'b1, 1'b0);
    look("sw_1cyc", MB + 4, 1'b1, 32'd0);
    cyc(MB + 4, 32'hFFFF, 1'b0, 1'b1);
    look("sw_2cyc", MB + 4, 1'b1, 32'h155);
    chk("sw_wr_noerr", 32'(bus_err), 32'd0);

`ifdef DMEM_TIMER_EN
    // Match latency, W1C, set-wins-over-clear
    cyc(MB + 32'hC, 32'd3, 1'b0, 1'b1);
    cyc(MB + 8, 32'd0, 1'b0, 1'b1);
    n = 0;
    while (n < 20 && !tmr_match) begin
      cyc(MB + 8, 32'h0, 1'b1, 1'b0);
      n++;
    end
    chk("match_latency", 32'(n), 32'(3 * PS));
    look("tcount_at_match", MB + 8, 1'b1, 32'd3);
    cyc(MB + 32'h10, 32'h1, 1'b0, 1'b1);
    chk("match_w1c", 32'(tmr_match), 32'd0);
    cyc(MB + 32'hC, 32'd11, 1'b0, 1'b1);
    cyc(MB + 8, 32'd10, 1'b0, 1'b1);
    for (int i = 0; i < PS - 1; i++) cyc(32'h0, 32'h0, 1'b0, 1'b0);
    cyc(MB + 32'h10, 32'h1, 1'b0, 1'b1);
    chk("match_set_wins", 32'(tmr_match), 32'd1);
    // TCOUNT wrap and write-on-tick override
    cyc(MB + 8, 32'hFFFF_FFFF, 1'b0, 1'b1);
    for (int i = 0; i < PS; i++) cyc(32'h0, 32'h0, 1'b0, 1'b0);
    look("tcount_wrap", MB + 8, 1'b1, 32'd0);
    for (int i = 0; i < PS - 1; i++) cyc(32'h0, 32'h0, 1'b0, 1'b0);
    cyc(MB + 8, 32'd5, 1'b0, 1'b1);
    look("tcount_wr_on_tick", MB + 8, 1'b1, 32'd5);
    cyc(32'h0, 32'h0, 1'b0, 1'b0);
    look("tcount_after", MB + 8, 1'b1, 32'd5);
`else
    cyc(MB + 8, 32'd7, 1'b0, 1'b1);
    cyc(MB + 32'hC, 32'd7, 1'b0, 1'b1);
    look("tcount_off", MB + 8, 1'b1, 32'd0);
    look("tcmp_off", MB + 32'hC, 1'b1, 32'd0);
    chk("timer_off_noerr", {30'd0, tmr_match, bus_err}, 32'd0);
`endif

    // Bus-error flag
    look("unmapped_rd", 32'h0002_0000, 1'b1, 32'd0);
    cyc(32'h0002_0000, 32'h0, 1'b1, 1'b0);
    chk("err_set", 32'(bus_err), 32'd1);
    cyc(MB + 32'h10, 32'h2, 1'b0, 1'b1);
    chk("err_w1c", 32'(bus_err), 32'd0);
    cyc(MB + 32'h14, 32'hFFFF_FFFF, 1'b0, 1'b1);
    chk("err_unmapped_wr", 32'(bus_err), 32'd1);
    cyc(MB, 32'h0, 1'b1, 1'b1);
    chk("err_sticky", 32'(bus_err), 32'd1);

    // Randomized phase over a small pre-written RAM region and all registers
    for (int i = 0; i < 8; i++) cyc(32'(i * 4), $urandom, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: a = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
        4: a = MB;
        5: a = MB + 4;
        6: a = MB + 8;
        7: a = MB + 32'hC;
        8: a = MB + 32'h10;
        default: begin
          n = $urandom_range(0, 2);
          a = (n == 0) ? MB + 32'h14 : (n == 1) ? 32'h0002_0000 : RAM_END;
        end
      endcase
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 2) == 0);
      wd = (sel == 6 || sel == 7) ? 32'($urandom_range(0, 12)) : $urandom;
      if ($urandom_range(0, 7) == 0) sw_in = 10'($urandom);
      cyc(a, wd, rd, wr);
    end

    // Asynchronous reset in the middle of a RAM write
    cyc(MB, 32'h2AA, 1'b0, 1'b1);
    cyc(MB + 8, 32'd9, 1'b0, 1'b1);
    daddr = 32'h10; ddata_w = 32'h0BAD_0BAD; MemRead = 1'b0; MemWrite = 1'b1;
    #1;
    RESET_N = 1'b0;
    #1;
    chk("rst_async_led", 32'(led_out), 32'd0);
    chk("rst_async_flags", {30'd0, tmr_match, bus_err}, 32'd0);
    @(posedge CLK);
    #1;
    m_reset();
    look("rst_tcount", MB + 8, 1'b1, 32'd0);
    look("rst_tcmp2", MB + 32'hC, 1'b1, TMR ? 32'hFFFF_FFFF : 32'd0);
    RESET_N = 1'b1;
    look("ram_kept", 32'h10, 1'b1, m_ram[4]);
    cyc(32'h10, 32'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
